// File: rtl/cgra_stream_ctrl.sv
// Sequences one CGRA run: fetches input lines from the host stream, hands them to
// the CGRA over valid/ready, and pushes the CGRA result lines back to the host.
module cgra_stream_ctrl #(
  parameter int DATA_W = 512,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  cfg_num_rd,
  input  logic [CNT_W-1:0]  cfg_num_wr,
  input  logic              available_read,
  output logic              req_rd_data,
  input  logic [DATA_W-1:0] rd_data,
  output logic              cgra_in_valid,
  output logic [DATA_W-1:0] cgra_in_data,
  input  logic              cgra_in_ready,
  input  logic              cgra_out_valid,
  input  logic [DATA_W-1:0] cgra_out_data,
  output logic              cgra_out_ready,
  input  logic              available_write,
  output logic              req_wr_data,
  output logic [DATA_W-1:0] wr_data,
  output logic              busy,
  output logic              done
);
  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [CNT_W-1:0]  num_rd_q, num_rd_d;
  logic [CNT_W-1:0]  num_wr_q, num_wr_d;
  logic [CNT_W-1:0]  rd_cnt_q, rd_cnt_d;
  logic [CNT_W-1:0]  wr_cnt_q, wr_cnt_d;
  logic              rd_pend_q, rd_pend_d;
  logic              in_full_q, in_full_d;
  logic              out_full_q, out_full_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic [DATA_W-1:0] in_buf_q, in_buf_d;
  logic [DATA_W-1:0] out_buf_q, out_buf_d;

  logic run, fin, rd_req, wr_req, out_rdy, in_xfer, out_xfer, last_wr;

  // fin covers the num_wr=0 run: the single RUN cycle must not fetch or accept.
  always_comb begin
    run      = (state_q == S_RUN);
    fin      = (wr_cnt_q == num_wr_q);
    rd_req   = run && !fin && available_read && (rd_cnt_q < num_rd_q)
               && !rd_pend_q && !in_full_q;
    out_rdy  = run && !fin && !out_full_q;
    wr_req   = out_full_q && available_write;
    in_xfer  = in_full_q && cgra_in_ready;
    out_xfer = out_rdy && cgra_out_valid;
    last_wr  = wr_req && ((wr_cnt_q + CNT_W'(1)) == num_wr_q);
  end

  always_comb begin
    state_d    = state_q;
    num_rd_d   = num_rd_q;
    num_wr_d   = num_wr_q;
    rd_cnt_d   = rd_cnt_q;
    wr_cnt_d   = wr_cnt_q;
    rd_pend_d  = rd_pend_q;
    in_full_d  = in_full_q;
    out_full_d = out_full_q;
    in_buf_d   = in_buf_q;
    out_buf_d  = out_buf_q;
    case (state_q)
      S_RUN: begin
        if (rd_req) begin
          rd_cnt_d  = rd_cnt_q + CNT_W'(1);
          rd_pend_d = 1'b1;
        end
        if (rd_pend_q) begin
          in_buf_d  = rd_data;
          in_full_d = 1'b1;
          rd_pend_d = 1'b0;
        end
        if (in_xfer) in_full_d = 1'b0;
        if (out_xfer) begin
          out_buf_d  = cgra_out_data;
          out_full_d = 1'b1;
        end
        if (wr_req) begin
          out_full_d = 1'b0;
          wr_cnt_d   = wr_cnt_q + CNT_W'(1);
        end
        // Leave RUN right after the final write so no surplus result is accepted;
        // any input still buffered or in flight is dropped.
        if (fin || last_wr) begin
          state_d   = S_DONE;
          rd_pend_d = 1'b0;
          in_full_d = 1'b0;
          in_buf_d  = '0;
        end
      end
      default: begin
        if (start) begin
          state_d    = S_RUN;
          num_rd_d   = cfg_num_rd;
          num_wr_d   = cfg_num_wr;
          rd_cnt_d   = '0;
          wr_cnt_d   = '0;
          rd_pend_d  = 1'b0;
          in_full_d  = 1'b0;
          out_full_d = 1'b0;
          in_buf_d   = '0;
          out_buf_d  = '0;
        end
      end
    endcase
    busy_d = (state_d == S_RUN);
    done_d = (state_d == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      num_rd_q   <= '0;
      num_wr_q   <= '0;
      rd_cnt_q   <= '0;
      wr_cnt_q   <= '0;
      rd_pend_q  <= 1'b0;
      in_full_q  <= 1'b0;
      out_full_q <= 1'b0;
      in_buf_q   <= '0;
      out_buf_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      num_rd_q   <= num_rd_d;
      num_wr_q   <= num_wr_d;
      rd_cnt_q   <= rd_cnt_d;
      wr_cnt_q   <= wr_cnt_d;
      rd_pend_q  <= rd_pend_d;
      in_full_q  <= in_full_d;
      out_full_q <= out_full_d;
      in_buf_q   <= in_buf_d;
      out_buf_q  <= out_buf_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
    end
  end

  assign req_rd_data    = rd_req;
  assign req_wr_data    = wr_req;
  assign cgra_in_valid  = in_full_q;
  assign cgra_in_data   = in_buf_q;
  assign cgra_out_ready = out_rdy;
  assign wr_data        = out_buf_q;
  assign busy           = busy_q;
  assign done           = done_q;

endmodule

// File: tb/tb_cgra_stream_ctrl.sv
// Scoreboard bench for cgra_stream_ctrl: random host/CGRA handshakes, a CGRA model
// that folds every E-th input into a result, and per-run count/timing checks.
module tb_cgra_stream_ctrl;
  localparam int DATA_W = 64;
  localparam int CNT_W  = 16;
  localparam logic [DATA_W-1:0] XPAT = 64'hA5A5_0F0F_3C3C_9696;

  logic              clk = 1'b0;
  logic              rst, start;
  logic [CNT_W-1:0]  cfg_num_rd, cfg_num_wr;
  logic              available_read, req_rd_data;
  logic [DATA_W-1:0] rd_data;
  logic              cgra_in_valid, cgra_in_ready;
  logic [DATA_W-1:0] cgra_in_data;
  logic              cgra_out_valid, cgra_out_ready;
  logic [DATA_W-1:0] cgra_out_data;
  logic              available_write, req_wr_data;
  logic [DATA_W-1:0] wr_data;
  logic              busy, done;

  always #5 clk = ~clk;

  cgra_stream_ctrl #(.DATA_W(DATA_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .start(start),
    .cfg_num_rd(cfg_num_rd), .cfg_num_wr(cfg_num_wr),
    .available_read(available_read), .req_rd_data(req_rd_data), .rd_data(rd_data),
    .cgra_in_valid(cgra_in_valid), .cgra_in_data(cgra_in_data), .cgra_in_ready(cgra_in_ready),
    .cgra_out_valid(cgra_out_valid), .cgra_out_data(cgra_out_data),
    .cgra_out_ready(cgra_out_ready),
    .available_write(available_write), .req_wr_data(req_wr_data), .wr_data(wr_data),
    .busy(busy), .done(done)
  );

  // Knobs written only by the stimulus process.
  int   echo_e = 1, free_n = 0, exp_rd_knob = 0, run_base = 0;
  logic ar_stuck = 1'b0, ir_stuck = 1'b0, aw_low = 1'b0, bp_arm = 1'b0;

  // State written only by the monitor process.
  int checks = 0, errors = 0, cyc = 0;
  int run_closed = 0, bp_done_cnt = 0, bp_left = 0;
  int rd_pulses = 0, wr_pulses = 0, n_in = 0, last_rd_cyc = 0, last_wr_cyc = 0;
  int start_cyc = 0, run_exp_rd = 0, run_exp_wr = 0, run_e = 1;
  logic rd_req_prev = 1'b0, done_prev = 1'b0, start_acc_prev = 1'b0, bp_taken = 1'b0;
  logic [DATA_W-1:0] bp_val, mon_v;
  logic [DATA_W-1:0] in_q[$], src_q[$], wr_q[$];

  task automatic chk_bit(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0b expected %0b at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic chk_data(input string name, input logic [DATA_W-1:0] act,
                          input logic [DATA_W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", name, act, exp, cyc);
    end
  endtask

  task automatic chk_int(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at cycle %0d", name, act, exp, cyc);
    end
  endtask

  // Host and CGRA driver: fresh random rd_data every cycle, random handshakes.
  always @(posedge clk) begin
    #1;
    rd_data         = {$urandom, $urandom};
    available_read  = ar_stuck ? 1'b1 : ($urandom_range(0, 3) != 0);
    cgra_in_ready   = ir_stuck ? 1'b1 : ($urandom_range(0, 2) != 0);
    available_write = aw_low ? 1'b0 : ($urandom_range(0, 3) != 0);
    if (src_q.size() > 0) begin
      cgra_out_valid = ($urandom_range(0, 2) != 0);
      cgra_out_data  = src_q[0];
    end else begin
      cgra_out_valid = 1'b0;
      cgra_out_data  = {$urandom, $urandom};
    end
  end

  // Monitor / scoreboard.
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk_bit("rst_req_rd_data", req_rd_data, 1'b0);
      chk_bit("rst_req_wr_data", req_wr_data, 1'b0);
      chk_bit("rst_cgra_in_valid", cgra_in_valid, 1'b0);
      chk_bit("rst_cgra_out_ready", cgra_out_ready, 1'b0);
      chk_bit("rst_busy", busy, 1'b0);
      chk_bit("rst_done", done, 1'b0);
      chk_data("rst_wr_data", wr_data, '0);
      chk_data("rst_cgra_in_data", cgra_in_data, '0);
      in_q.delete(); src_q.delete(); wr_q.delete();
      rd_req_prev = 1'b0; done_prev = 1'b0; start_acc_prev = 1'b0; bp_left = 0;
    end else begin
      if (start_acc_prev) begin
        chk_bit("start_busy", busy, 1'b1);
        chk_bit("start_done_low", done, 1'b0);
      end else if (done_prev) begin
        chk_bit("done_hold", done, 1'b1);
      end
      if (rd_req_prev) in_q.push_back(rd_data);
      if (bp_left > 0) begin
        chk_bit("bp_ready_low", cgra_out_ready, 1'b0);
        chk_bit("bp_no_wr", req_wr_data, 1'b0);
        chk_data("bp_hold", wr_data, bp_val);
        bp_left--;
        if (bp_left == 0) bp_done_cnt++;
      end
      if (!bp_arm) bp_taken = 1'b0;
      if (cgra_in_valid && cgra_in_ready) begin
        if (in_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL cgra_in_unexpected: got %0h expected no line at cycle %0d",
                   cgra_in_data, cyc);
        end else begin
          mon_v = in_q.pop_front();
          chk_data("cgra_in_data", cgra_in_data, mon_v);
          n_in++;
          if (run_e != 0 && (n_in % run_e) == 0) src_q.push_back(mon_v ^ XPAT);
        end
      end
      if (cgra_out_valid && cgra_out_ready && src_q.size() > 0) begin
        if (bp_arm && !bp_taken) begin
          bp_taken = 1'b1; bp_left = 10; bp_val = src_q[0];
        end
        wr_q.push_back(src_q.pop_front());
      end
      if (req_wr_data) begin
        if (wr_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_unexpected: got %0h expected no write at cycle %0d", wr_data, cyc);
        end else begin
          mon_v = wr_q.pop_front();
          chk_data("wr_data", wr_data, mon_v);
        end
        wr_pulses++; last_wr_cyc = cyc;
      end
      if (req_rd_data) begin
        if (rd_pulses > 0) begin
          checks++;
          if (cyc - last_rd_cyc < 2) begin
            errors++;
            $display("FAIL rd_spacing: got %0d expected >=2 at cycle %0d", cyc - last_rd_cyc, cyc);
          end
        end
        rd_pulses++; last_rd_cyc = cyc;
      end
      if (req_rd_data || req_wr_data || cgra_out_ready) chk_bit("strobe_in_run", busy, 1'b1);
      if (done && !done_prev) begin
        chk_int("run_rd_pulses", rd_pulses, run_exp_rd);
        chk_int("run_wr_pulses", wr_pulses, run_exp_wr);
        chk_int("run_wr_left", wr_q.size(), 0);
        if (run_exp_wr == 0) chk_int("done_after_start", cyc - start_cyc, 2);
        else chk_int("done_after_last_wr", cyc - last_wr_cyc, 1);
        run_closed++;
      end
      done_prev      = done;
      rd_req_prev    = req_rd_data;
      start_acc_prev = start && !busy;
      if (start_acc_prev) begin
        in_q.delete(); src_q.delete(); wr_q.delete();
        rd_pulses = 0; wr_pulses = 0; n_in = 0; start_cyc = cyc;
        run_exp_rd = exp_rd_knob; run_exp_wr = int'(cfg_num_wr); run_e = echo_e;
        for (int i = 0; i < free_n; i++) src_q.push_back({$urandom, $urandom});
      end
    end
  end

  task automatic start_run(input int nr, input int nw, input int e, input int xr, input int fr);
    @(posedge clk); #1;
    cfg_num_rd = CNT_W'(nr); cfg_num_wr = CNT_W'(nw);
    echo_e = e; exp_rd_knob = xr; free_n = fr;
    run_base = run_closed;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    cfg_num_rd = CNT_W'($urandom); cfg_num_wr = CNT_W'($urandom);
  endtask

  task automatic wait_done();
    for (int i = 0; i < 3000 && run_closed == run_base; i++) @(posedge clk);
    if (run_closed == run_base) begin
      $display("FAIL run_timeout: done not seen, rd %0d wr %0d at cycle %0d", rd_pulses, wr_pulses, cyc);
      $fatal(1);
    end
  endtask

  task automatic do_run(input int nr, input int nw, input int e, input int xr, input int fr);
    start_run(nr, nw, e, xr, fr);
    wait_done();
  endtask

  initial begin
    int b, e, nw;
    rst = 1'b1; start = 1'b0; cfg_num_rd = '0; cfg_num_wr = '0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    do_run(4, 2, 2, 4, 0);

    ar_stuck = 1'b1; ir_stuck = 1'b1;
    do_run(6, 6, 1, 6, 0);
    ar_stuck = 1'b0; ir_stuck = 1'b0;

    bp_arm = 1'b1; aw_low = 1'b1;
    b = bp_done_cnt;
    start_run(2, 2, 1, 2, 0);
    for (int i = 0; i < 500 && bp_done_cnt == b; i++) @(posedge clk);
    if (bp_done_cnt == b) begin
      $display("FAIL bp_timeout: out buffer never filled at cycle %0d", cyc);
      $fatal(1);
    end
    #1 aw_low = 1'b0;
    wait_done();
    bp_arm = 1'b0;

    do_run(0, 0, 1, 0, 0);
    do_run(5, 0, 1, 0, 0);
    do_run(0, 1, 0, 0, 1);
    do_run(0, 3, 0, 0, 3);

    do_run(1, 1, 1, 1, 0);
    start_run(4, 4, 1, 4, 0);
    repeat (3) @(posedge clk);
    #1 cfg_num_rd = 16'd9; cfg_num_wr = 16'd9; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    wait_done();

    start_run(8, 8, 1, 8, 0);
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    do_run(2, 1, 2, 2, 0);

    for (int k = 0; k < 8; k++) begin
      e  = int'($urandom_range(1, 3));
      nw = int'($urandom_range(1, 4));
      do_run(e * nw, nw, e, e * nw, 0);
    end

    repeat (4) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
